// File: rtl/banco_regs_multiporta_pkg.sv
// Shared definitions for the multi-port register bank.
//   estado_t : controller state (ST_LIMPANDO clears the array, ST_OPERANDO is normal use)
//   clog2    : address width helper, never returns less than 1
package banco_regs_multiporta_pkg;

  typedef enum logic {
    ST_LIMPANDO = 1'b0,
    ST_OPERANDO = 1'b1
  } estado_t;

  function automatic int clog2(input int valor);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << res) < valor) res++;
    end
    if (res < 1) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/banco_porta_leit.sv
// One registered read port of the register bank.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   limpando     : bank is running its clear sequence; the port returns zero
//   addRd        : read address for this port
//   regs         : current contents of the storage array
//   wrAceito     : a write is being accepted this cycle (already filtered)
//   addWr/dadoWr : address and data of that write, used for write-first forwarding
//   dadoRd       : read data, one cycle after addRd is sampled
module banco_porta_leit #(
  parameter int LARGURA   = 32,
  parameter int NUM_REGS  = 32,
  parameter int AW        = 5,
  parameter int ZERO_FIXO = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpando,
  input  logic [AW-1:0]      addRd,
  input  logic [LARGURA-1:0] regs [NUM_REGS],
  input  logic               wrAceito,
  input  logic [AW-1:0]      addWr,
  input  logic [LARGURA-1:0] dadoWr,
  output logic [LARGURA-1:0] dadoRd
);

  localparam logic [AW:0] LIMITE = (AW+1)'(NUM_REGS);

  logic               foraFaixa;
  logic               zeroFixo;
  logic [LARGURA-1:0] proximo_p0;
  logic [LARGURA-1:0] dadoRd_p1;

  // Stage p0: mask, forward or fetch
  always_comb begin
    foraFaixa  = ({1'b0, addRd} >= LIMITE);
    zeroFixo   = (ZERO_FIXO != 0) && (addRd == '0);
    proximo_p0 = '0;
    // Masking comes first: an accepted write can never target a masked address,
    // and the array index is only evaluated once the address is known in range.
    if (limpando || foraFaixa || zeroFixo) begin
      proximo_p0 = '0;
    end else if (wrAceito && (addWr == addRd)) begin
      proximo_p0 = dadoWr;
    end else begin
      proximo_p0 = regs[addRd];
    end
  end

  // Stage p1: registered read data
  always_ff @(posedge clock) begin
    if (reset) dadoRd_p1 <= '0;
    else       dadoRd_p1 <= proximo_p0;
  end

  assign dadoRd = dadoRd_p1;

endmodule

// File: rtl/banco_regs_multiporta.sv
// Register bank with one write port and NUM_LEIT registered read ports.
// After reset the whole array is cleared, one register per cycle, while
// ocupado is high; writes are ignored and reads return zero during that time.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   wr_en, add_wr, dado_wr : write request, address, data
//   add_rd  : flattened read addresses, port k at [k*AW +: AW]
//   dado_rd : flattened read data, port k at [k*LARGURA +: LARGURA], 1-cycle latency
//   ocupado : high while the clear sequence runs
module banco_regs_multiporta
  import banco_regs_multiporta_pkg::*;
#(
  parameter  int LARGURA   = 32,
  parameter  int NUM_REGS  = 32,
  parameter  int NUM_LEIT  = 2,
  parameter  int ZERO_FIXO = 1,
  localparam int AW        = clog2(NUM_REGS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 add_wr,
  input  logic [LARGURA-1:0]            dado_wr,
  input  logic [NUM_LEIT*AW-1:0]        add_rd,
  output logic [NUM_LEIT*LARGURA-1:0]   dado_rd,
  output logic                          ocupado
);

  localparam logic [AW:0]   LIMITE = (AW+1)'(NUM_REGS);
  localparam logic [AW-1:0] ULTIMO = AW'(NUM_REGS - 1);

  estado_t            estado;
  logic [AW-1:0]      ptr;
  logic [LARGURA-1:0] regs [NUM_REGS];

  logic               limpando;
  logic               wrAceito;
  logic               wrAtivo;
  logic [AW-1:0]      wrAddr;
  logic [LARGURA-1:0] wrDado;

  assign limpando = (estado == ST_LIMPANDO);
  assign ocupado  = limpando;

  // Single write path: the clear pointer owns it during LIMPANDO, the user
  // port afterwards. A user write in a reset cycle is dropped.
  always_comb begin
    wrAceito = !reset && !limpando && wr_en &&
               ({1'b0, add_wr} < LIMITE) &&
               !((ZERO_FIXO != 0) && (add_wr == '0));
    wrAtivo  = limpando || wrAceito;
    wrAddr   = limpando ? ptr : add_wr;
    wrDado   = limpando ? '0  : dado_wr;
  end

  always_ff @(posedge clock) begin
    if (wrAtivo) regs[wrAddr] <= wrDado;
  end

  // Clear controller: NUM_REGS cycles in LIMPANDO, then stays in OPERANDO
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= ST_LIMPANDO;
      ptr    <= '0;
    end else begin
      case (estado)
        ST_LIMPANDO: begin
          if (ptr == ULTIMO) estado <= ST_OPERANDO;
          else               ptr    <= ptr + 1'b1;
        end
        ST_OPERANDO: estado <= ST_OPERANDO;
        default:     estado <= ST_LIMPANDO;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_LEIT; k++) begin : g_porta
    banco_porta_leit #(
      .LARGURA   (LARGURA),
      .NUM_REGS  (NUM_REGS),
      .AW        (AW),
      .ZERO_FIXO (ZERO_FIXO)
    ) u_porta (
      .clock    (clock),
      .reset    (reset),
      .limpando (limpando),
      .addRd    (add_rd[k*AW +: AW]),
      .regs     (regs),
      .wrAceito (wrAceito),
      .addWr    (add_wr),
      .dadoWr   (dado_wr),
      .dadoRd   (dado_rd[k*LARGURA +: LARGURA])
    );
  end

endmodule

// File: tb/tb_banco_regs_multiporta.sv
// Bench for banco_regs_multiporta: a default instance (32x32, 2 ports) and a
// 24-register, 16-bit, 4-port instance checked against an array model.
module tb_banco_regs_multiporta;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: defaults
  logic        resetA, wrEnA, ocupadoA;
  logic [4:0]  addWrA;
  logic [31:0] dadoWrA;
  logic [9:0]  addRdA;
  logic [63:0] dadoRdA;

  // Instance B: NUM_REGS=24, NUM_LEIT=4, LARGURA=16
  logic        resetB, wrEnB, ocupadoB;
  logic [4:0]  addWrB;
  logic [15:0] dadoWrB;
  logic [19:0] addRdB;
  logic [63:0] dadoRdB;

  banco_regs_multiporta dutA (
    .clock   (clock),
    .reset   (resetA),
    .wr_en   (wrEnA),
    .add_wr  (addWrA),
    .dado_wr (dadoWrA),
    .add_rd  (addRdA),
    .dado_rd (dadoRdA),
    .ocupado (ocupadoA)
  );

  banco_regs_multiporta #(
    .LARGURA  (16),
    .NUM_REGS (24),
    .NUM_LEIT (4)
  ) dutB (
    .clock   (clock),
    .reset   (resetB),
    .wr_en   (wrEnB),
    .add_wr  (addWrB),
    .dado_wr (dadoWrB),
    .add_rd  (addRdB),
    .dado_rd (dadoRdB),
    .ocupado (ocupadoB)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] modeloB [32];

  task automatic confere(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts samples with ocupado high; every read during the clear must be zero.
  task automatic esperaLivreA(output int n);
    n = 0;
    while (ocupadoA === 1'b1 && n < 200) begin
      confere("A_leit_limpando", dadoRdA, 64'h0);
      n++;
      tick();
    end
  endtask

  task automatic esperaLivreB(output int n);
    n = 0;
    while (ocupadoB === 1'b1 && n < 200) begin
      confere("B_leit_limpando", dadoRdB, 64'h0);
      n++;
      tick();
    end
  endtask

  // Expected read of one B port given this cycle's write request
  function automatic logic [15:0] refLeitB(int a, bit we, int aw, logic [15:0] d);
    if (a >= 24 || a == 0) return 16'h0;
    if (we && aw == a) return d;
    return modeloB[a];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int pool [23];
    int ad [4];
    bit we;
    int aw;
    logic [15:0] d;
    logic [15:0] esp [4];

    resetA = 1'b1; wrEnA = 1'b0; addWrA = '0; dadoWrA = '0; addRdA = {5'd3, 5'd1};
    resetB = 1'b1; wrEnB = 1'b0; addWrB = '0; dadoWrB = '0; addRdB = '0;
    tick();
    resetA = 1'b0;

    // Reset state and clear length
    confere("A_rst_ocupado", 64'(ocupadoA), 64'h1);
    confere("A_rst_dado", dadoRdA, 64'h0);
    esperaLivreA(n);
    confere("A_limpeza_ciclos", 64'(n), 64'd32);
    confere("A_ocupado_fim", 64'(ocupadoA), 64'h0);

    for (int i = 0; i < 16; i++) begin
      addRdA = {5'(2*i+1), 5'(2*i)};
      tick();
      confere("A_zero_ini", dadoRdA, 64'h0);
    end

    // Write then read on both ports
    wrEnA = 1'b1; addWrA = 5'd5; dadoWrA = 32'hDEADBEEF; addRdA = {5'd0, 5'd0};
    tick();
    wrEnA = 1'b0; addRdA = {5'd5, 5'd5};
    tick();
    confere("A_r5_p0", 64'(dadoRdA[31:0]),  64'hDEADBEEF);
    confere("A_r5_p1", 64'(dadoRdA[63:32]), 64'hDEADBEEF);

    // Forwarding on port 1, port 0 reads stored r5
    wrEnA = 1'b1; addWrA = 5'd7; dadoWrA = 32'h12345678; addRdA = {5'd7, 5'd5};
    tick();
    wrEnA = 1'b0;
    confere("A_fwd_r7_p1", 64'(dadoRdA[63:32]), 64'h12345678);
    confere("A_fwd_r5_p0", 64'(dadoRdA[31:0]),  64'hDEADBEEF);
    tick();
    confere("A_r7_p1", 64'(dadoRdA[63:32]), 64'h12345678);

    // Register 0 is hardwired to zero
    wrEnA = 1'b1; addWrA = 5'd0; dadoWrA = 32'hFFFFFFFF; addRdA = {5'd0, 5'd0};
    tick();
    wrEnA = 1'b0;
    confere("A_r0_mesmo_ciclo", dadoRdA, 64'h0);
    tick();
    confere("A_r0_depois", dadoRdA, 64'h0);

    // Reset in the middle of operation
    wrEnA = 1'b1; addWrA = 5'd3; dadoWrA = 32'hA5A5A5A5;
    tick();
    addWrA = 5'd20; dadoWrA = 32'h0BADF00D; addRdA = {5'd20, 5'd3};
    tick();
    wrEnA = 1'b0;
    tick();
    confere("A_r3_antes", 64'(dadoRdA[31:0]),  64'hA5A5A5A5);
    confere("A_r20_antes", 64'(dadoRdA[63:32]), 64'h0BADF00D);
    repeat (5) tick();

    resetA = 1'b1; wrEnA = 1'b1; addWrA = 5'd9; dadoWrA = 32'h99999999; addRdA = {5'd20, 5'd20};
    tick();
    resetA = 1'b0; addWrA = 5'd10; dadoWrA = 32'h11111111;
    esperaLivreA(n);
    wrEnA = 1'b0;
    confere("A_limpeza2_ciclos", 64'(n), 64'd32);
    addRdA = {5'd10, 5'd9};
    tick();
    confere("A_escrita_ignorada", dadoRdA, 64'h0);
    addRdA = {5'd20, 5'd3};
    tick();
    confere("A_r3_r20_limpos", dadoRdA, 64'h0);

    // Reset during the clear restarts it from the beginning
    resetA = 1'b1;
    tick();
    resetA = 1'b0;
    repeat (5) tick();
    resetA = 1'b1;
    tick();
    resetA = 1'b0;
    esperaLivreA(n);
    confere("A_limpeza3_ciclos", 64'(n), 64'd32);

    // Instance B: out-of-range and zero register, then randomized reads
    tick();
    resetB = 1'b0;
    esperaLivreB(n);
    confere("B_limpeza_ciclos", 64'(n), 64'd24);
    for (int i = 0; i < 32; i++) modeloB[i] = 16'h0;

    wrEnB = 1'b1; addWrB = 5'd30; dadoWrB = 16'hFFFF; addRdB = {5'd30, 5'd30, 5'd30, 5'd30};
    tick();
    confere("B_r30_fwd", dadoRdB, 64'h0);
    addWrB = 5'd0; addRdB = {5'd0, 5'd30, 5'd0, 5'd30};
    tick();
    wrEnB = 1'b0;
    confere("B_r0_fwd", dadoRdB, 64'h0);
    tick();
    confere("B_r0_r30_depois", dadoRdB, 64'h0);

    for (int a = 1; a < 24; a++) begin
      wrEnB = 1'b1; addWrB = 5'(a); dadoWrB = 16'($urandom);
      modeloB[a] = dadoWrB;
      tick();
    end
    wrEnB = 1'b0;

    for (int c = 0; c < 100; c++) begin
      for (int i = 0; i < 23; i++) pool[i] = i + 1;
      for (int j = 0; j < 4; j++) begin
        int r, t;
        r = $urandom_range(22, j);
        t = pool[j]; pool[j] = pool[r]; pool[r] = t;
        ad[j] = pool[j];
      end
      we = 1'($urandom_range(1, 0));
      aw = $urandom_range(31, 0);
      d  = 16'($urandom);
      wrEnB = we; addWrB = 5'(aw); dadoWrB = d;
      addRdB = {5'(ad[3]), 5'(ad[2]), 5'(ad[1]), 5'(ad[0])};
      // A write is accepted only to an in-range, non-zero register
      if (aw >= 24 || aw == 0) we = 1'b0;
      for (int k = 0; k < 4; k++) esp[k] = refLeitB(ad[k], we, aw, d);
      tick();
      for (int k = 0; k < 4; k++) confere($sformatf("B_rand_c%0d_p%0d", c, k), 64'(dadoRdB[k*16 +: 16]), 64'(esp[k]));
      if (we) modeloB[aw] = d;
    end
    wrEnB = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banco_regs_multiporta.md
BANCO_REGS_MULTIPORTA -- requirements
Module: banco_regs_multiporta

Interface
REQ-001 The block SHALL have parameter LARGURA, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning register count; legal range 2..256.
REQ-003 The block SHALL have parameter NUM_LEIT, default 2, meaning number of read ports; legal range 1..4.
REQ-004 The block SHALL have parameter ZERO_FIXO, default 1, meaning that register 0 reads as zero and ignores writes.
REQ-005 The block SHALL use local constant AW = clog2(NUM_REGS), minimum 1, as the address width.
REQ-006 The block SHALL have port clock, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, the reset; reset is synchronous and active-high.
REQ-008 The block SHALL have port wr_en, input, 1 bit, the write request.
REQ-009 The block SHALL have port add_wr, input, AW bits, the write address.
REQ-010 The block SHALL have port dado_wr, input, LARGURA bits, the write data.
REQ-011 The block SHALL have port add_rd, input, NUM_LEIT*AW bits, the flattened read addresses; port k occupies bits [k*AW +: AW].
REQ-012 The block SHALL have port dado_rd, output, NUM_LEIT*LARGURA bits, the flattened registered read data; port k occupies bits [k*LARGURA +: LARGURA].
REQ-013 The block SHALL have port ocupado, output, 1 bit, high while the clear sequence runs.

Function
REQ-014 The block SHALL have a two-state FSM: LIMPANDO and OPERANDO.
REQ-015 In LIMPANDO, a counter ptr SHALL start at 0 and write zero to register ptr every cycle, then increment.
REQ-016 When ptr = NUM_REGS-1 has been cleared, the FSM SHALL go to OPERANDO on the next edge, so LIMPANDO lasts exactly NUM_REGS cycles.
REQ-017 ocupado SHALL be 1 exactly while the state is LIMPANDO.
REQ-018 In LIMPANDO, wr_en SHALL be ignored; there is no queuing of writes.
REQ-019 In OPERANDO, wr_en=1 with add_wr < NUM_REGS SHALL store dado_wr at the edge.
REQ-020 If add_wr >= NUM_REGS, the write SHALL be dropped.
REQ-021 If ZERO_FIXO=1 and add_wr=0, the write SHALL be dropped.
REQ-022 Read latency SHALL be 1 cycle: dado_rd[k] at edge n+1 reflects add_rd[k] sampled at edge n.
REQ-023 Forwarding: if a write that is accepted at edge n targets the same address as read port k at edge n, dado_rd[k] SHALL return dado_wr (write-first).
REQ-024 A read of an address >= NUM_REGS SHALL return 0.
REQ-025 With ZERO_FIXO=1, a read of address 0 SHALL return 0.
REQ-026 In LIMPANDO, all dado_rd ports SHALL return 0.
REQ-027 All read ports SHALL be independent; any ports may read the same address in the same cycle.

Reset
REQ-028 On reset=1 at an edge, the state SHALL be LIMPANDO, ptr SHALL be 0, dado_rd SHALL be 0 on all ports, and ocupado SHALL be 1 from the next cycle.
REQ-029 Reset asserted mid-LIMPANDO or mid-operation SHALL restart the full clear sequence from ptr=0.
REQ-030 A write presented in the same cycle as reset SHALL be discarded.

Structure
REQ-031 A shared package (or include file) SHALL define the state encoding constants ST_LIMPANDO and ST_OPERANDO, and the clog2 function.
REQ-032 The block SHALL use one sub-module, banco_porta_leit, instantiated NUM_LEIT times; each instance holds one read register with its forwarding and zero/range masking.
REQ-033 Storage SHALL be a NUM_REGS x LARGURA register array written from a single write path; that path is muxed between the clear pointer and add_wr.

Verification
REQ-034 Reset for 1 cycle with defaults: ocupado=1 for exactly 32 cycles, then 0; every register then reads 0x00000000.
REQ-035 In OPERANDO, write 0xDEADBEEF to r5; the next cycle, read r5 on port 0 and r5 on port 1: both ports return 0xDEADBEEF one cycle later.
REQ-036 Same cycle, write 0x12345678 to r7 and read r7 on port 1: port 1 returns 0x12345678 after 1 cycle (forwarding).
REQ-037 Write 0xFFFFFFFF to r0 with ZERO_FIXO=1: a read of r0 returns 0; with NUM_REGS=24, a write to r30 is dropped and a read of r30 returns 0.
REQ-038 Write 0xA5A5A5A5 to r3, assert reset 10 cycles into OPERANDO, then wait for ocupado to fall: r3 reads 0; writes issued while ocupado=1 do not land.
REQ-039 With NUM_LEIT=4 and LARGURA=16, four ports read four distinct preloaded registers each cycle for 100 random cycles; the outputs match a reference model.
